// File: rtl/seq_magnitude_compare.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, start/done handshake.
// Optional macro SEQ_CMP_EARLY_EXIT_EN: finish as soon as the first differing digit is seen.
module seq_magnitude_compare #(
    parameter int WIDTH  = 16,
    parameter int DIGIT  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // state  | meaning
    // S_IDLE | waiting for start, ready = 1
    // S_RUN  | comparing one digit per cycle, MSB digit first
    // S_DONE | loading results; done pulses on the way back to idle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Flipping the sign bit maps two's complement onto offset binary.
    localparam logic [WIDTH-1:0] MSB_MASK = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CNT_W-1:0] cnt;
    logic             decided, pend_gt, pend_lt;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             diff;

    assign dig_a = a_sh[WIDTH-1 -: DIGIT];
    assign dig_b = b_sh[WIDTH-1 -: DIGIT];
    assign diff  = (dig_a != dig_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (cnt == '0) state_nxt = S_DONE;
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (!decided && diff) state_nxt = S_DONE;
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            pend_gt <= 1'b0;
            pend_lt <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a ^ MSB_MASK;
                        b_sh    <= b ^ MSB_MASK;
                        cnt     <= CNT_W'(NDIG - 1);
                        decided <= 1'b0;
                        pend_gt <= 1'b0;
                        pend_lt <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Only the first differing digit decides; later ones are ignored.
                    if (!decided && diff) begin
                        decided <= 1'b1;
                        pend_gt <= (dig_a > dig_b);
                        pend_lt <= !(dig_a > dig_b);
                    end
                    a_sh <= a_sh << DIGIT;
                    b_sh <= b_sh << DIGIT;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    done <= 1'b1;
                    gt   <= pend_gt;
                    lt   <= pend_lt;
                    eq   <= ~decided;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Bench for seq_magnitude_compare: unsigned and signed instances driven in parallel,
// checked against an arithmetic reference model.
module tb_seq_magnitude_compare;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int ND = W / D;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic         ready_u, done_u, gt_u, eq_u, lt_u;
    logic         ready_s, done_s, gt_s, eq_s, lt_s;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    seq_magnitude_compare #(.WIDTH(W), .DIGIT(D), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready_u), .done(done_u), .gt(gt_u), .eq(eq_u), .lt(lt_u));

    seq_magnitude_compare #(.WIDTH(W), .DIGIT(D), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready_s), .done(done_s), .gt(gt_s), .eq(eq_s), .lt(lt_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {gt, eq, lt} from plain arithmetic
    function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        if (sgn) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    // Edges from acceptance until done is visible
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        logic [W-1:0] xo, yo;
        xo = sgn ? (x ^ {1'b1, {(W-1){1'b0}}}) : x;
        yo = sgn ? (y ^ {1'b1, {(W-1){1'b0}}}) : y;
`ifdef SEQ_CMP_EARLY_EXIT_EN
        for (int i = 0; i < ND; i++)
            if (xo[W-1-D*i -: D] != yo[W-1-D*i -: D]) return i + 2;
`endif
        if (xo == yo) return ND + 1;
        return ND + 1;
    endfunction

    task automatic start_cmp(input logic [W-1:0] ta, input logic [W-1:0] tbv);
        @(negedge clk);
        check("ready_u before start", {31'b0, ready_u}, 32'd1);
        check("ready_s before start", {31'b0, ready_s}, 32'd1);
        a = ta; b = tbv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after acceptance edge k plus pre_edges further edges.
    task automatic run_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                 input int pre_edges);
        int nu = 0, ns = 0;
        logic [2:0] ru = '0, rs = '0;
        for (int n = pre_edges + 1; n <= 40 && (nu == 0 || ns == 0); n++) begin
            @(posedge clk); #1;
            if (nu == 0 && done_u) begin nu = n; ru = {gt_u, eq_u, lt_u}; end
            else if (nu == 0) check({tag, " ready_u busy"}, {31'b0, ready_u}, 32'd0);
            if (ns == 0 && done_s) begin ns = n; rs = {gt_s, eq_s, lt_s}; end
        end
        check({tag, " lat_u"}, nu, exp_lat(ta, tbv, 1'b0));
        check({tag, " lat_s"}, ns, exp_lat(ta, tbv, 1'b1));
        check({tag, " res_u"}, {29'b0, ru}, {29'b0, exp_res(ta, tbv, 1'b0)});
        check({tag, " res_s"}, {29'b0, rs}, {29'b0, exp_res(ta, tbv, 1'b1)});
        @(posedge clk); #1;
        check({tag, " done_u pulse"}, {31'b0, done_u}, 32'd0);
        check({tag, " done_s pulse"}, {31'b0, done_s}, 32'd0);
        check({tag, " hold_u"}, {29'b0, gt_u, eq_u, lt_u}, {29'b0, exp_res(ta, tbv, 1'b0)});
        check({tag, " hold_s"}, {29'b0, gt_s, eq_s, lt_s}, {29'b0, exp_res(ta, tbv, 1'b1)});
    endtask

    initial begin
        int         nd;
        int         done_times[$];
        logic [W-1:0] ta, tbv;

        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset outs_u", {27'b0, ready_u, done_u, gt_u, eq_u, lt_u}, 32'b10000);
        check("reset outs_s", {27'b0, ready_s, done_s, gt_s, eq_s, lt_s}, 32'b10000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        start_cmp(16'h1234, 16'h1234); run_and_check("eq1234", 16'h1234, 16'h1234, 0);
        start_cmp(16'h8000, 16'h7FFF); run_and_check("8000v7fff", 16'h8000, 16'h7FFF, 0);
        start_cmp(16'hFFFF, 16'h0001); run_and_check("ffffv0001", 16'hFFFF, 16'h0001, 0);
        start_cmp(16'hF000, 16'h0000); run_and_check("f000v0", 16'hF000, 16'h0000, 0);
        start_cmp(16'hABCD, 16'hABCD); run_and_check("eqabcd", 16'hABCD, 16'hABCD, 0);

        // operands change while the compare is in flight
        start_cmp(16'h1235, 16'h1234);
        a = 16'h0000; b = 16'hFFFF;
        run_and_check("midchange", 16'h1235, 16'h1234, 0);

        // start pulse while busy must be ignored, not queued
        start_cmp(16'h1234, 16'h1235);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        run_and_check("busy", 16'h1234, 16'h1235, 2);
        nd = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_u || done_s || !ready_u) nd++;
        end
        check("busy not queued", nd, 0);

        // reset mid-compare discards it
        start_cmp(16'h1234, 16'h1230);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1; #1;
        check("midreset outs_u", {27'b0, ready_u, done_u, gt_u, eq_u, lt_u}, 32'b10000);
        check("midreset outs_s", {27'b0, ready_s, done_s, gt_s, eq_s, lt_s}, 32'b10000);
        @(negedge clk); reset = 1'b0;
        nd = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done_u || done_s) nd++;
        end
        check("midreset no done", nd, 0);
        start_cmp(16'h0FFF, 16'h1000); run_and_check("postreset", 16'h0FFF, 16'h1000, 0);

        // start held high: back-to-back compares every NDIG+2 cycles
        @(negedge clk); a = 16'h5555; b = 16'h5555; start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 2 * ND + 3; n++) begin
            @(posedge clk); #1;
            if (done_u) done_times.push_back(n);
        end
        start = 1'b0;
        check("held count", done_times.size(), 2);
        if (done_times.size() == 2) begin
            check("held first", done_times[0], ND + 1);
            check("held second", done_times[1], 2 * ND + 3);
        end
        repeat (2) @(posedge clk);

        for (int i = 0; i < 40; i++) begin
            ta = W'($urandom);
            case ($urandom_range(0, 2))
                0:       tbv = W'($urandom);
                1:       tbv = ta;
                default: tbv = ta ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            start_cmp(ta, tbv);
            run_and_check("rand", ta, tbv, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_magnitude_compare.md
Name: seq_magnitude_compare

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Compares DIGIT bits per clock, MSB-first, and reports registered gt/eq/lt with a start/done handshake.
- Supports unsigned or two's-complement operands.
- Sits beside datapath blocks that need wide compares at low LUT cost where latency is acceptable.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT digits; 1 <= DIGIT <= WIDTH.
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- ready  output  1  high in IDLE only; combinational decode of state.
- done  output  1  single-cycle pulse; results valid and updated in this cycle.
- gt  output  1  registered; latched A > B.
- eq  output  1  registered; latched A == B.
- lt  output  1  registered; latched A < B.

Behaviour:
- Reset (async, any state, including mid-compare):
  - state = IDLE; done = 0; gt = eq = lt = 0; digit counter = 0; decision flag cleared.
  - Any in-progress compare is discarded; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready = 1.
  - start = 1 at edge k latches a and b into shadow registers, sets cnt = NDIG-1, clears the decided flag and the pending gt/lt, and moves to RUN.
- Sign handling:
  - When SIGNED = 1, the MSB of both latched operands is inverted at latch time (offset binary), so the whole compare is unsigned.
- RUN, one digit per cycle, digit index cnt (MSB digit first):
  - If not decided and digitA != digitB, set decided and set pending gt = (digitA > digitB), pending lt = its inverse.
  - If decided is already set, later digits have no effect.
  - cnt == 0 moves to DONE; otherwise cnt decrements.
- DONE:
  - done = 1 for this cycle only.
  - gt/lt are loaded from the pending values; eq = ~decided. Exactly one of gt/eq/lt is high.
  - Next state is IDLE.
- Latency:
  - start accepted at edge k; RUN spans cycles k+1..k+NDIG; done is high in the cycle after edge k+NDIG+1.
  - Throughput is one compare per NDIG+2 cycles.
- Result hold: gt/eq/lt hold their values until the next done pulse or reset.
- Handshake rules:
  - start while ready = 0 is ignored and not queued.
  - start held high continuously issues a new compare each time IDLE is re-entered.
- Operand changes on a/b after acceptance have no effect on the compare in flight.
- NDIG = 1 (DIGIT = WIDTH): RUN lasts exactly one cycle.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined: RUN moves to DONE in the same cycle the first differing digit is found.
  - Latency becomes (index of first differing digit from MSB, 1-based) + 1 edges after acceptance.
  - Equal operands still take the full NDIG+1.
- Undefined: fixed latency NDIG+1 for all operands, as above.

Test Plan:
- WIDTH=16, DIGIT=4, SIGNED=0; a=0x1234, b=0x1234, start at edge k -> done at k+5; eq=1, gt=lt=0; ready low k+1..k+5.
- Same configuration; a=0x8000, b=0x7FFF -> gt=1. Rebuild with SIGNED=1, same operands -> lt=1. Also a=0xFFFF, b=0x0001 signed -> lt=1.
- a=0x1235, b=0x1234 (difference in the last digit) -> gt=1, done at k+5. Then change a/b to 0x0000/0xFFFF during RUN -> result still gt=1.
- Second start pulse at k+2 while busy -> ignored; exactly one done pulse; ready returns at k+6.
- Assert reset at k+3 mid-compare -> immediately state IDLE, gt/eq/lt = 0, no done. A new start after release completes normally.
- With SEQ_CMP_EARLY_EXIT_EN: a=0xF000, b=0x0000 -> done at k+2, gt=1. With a=b=0xABCD -> done at k+5, eq=1.
